// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the multi-channel PWM peripheral: the per-channel
// register offsets, the bit positions inside the control and status registers,
// and a helper that sizes the peripheral's byte-address window.
// -----------------------------------------------------------------------------
package pwm_pkg;

    // Byte offsets of the four registers inside one channel's 8-byte slot.
    typedef enum logic [2:0] {
        REG_MAX  = 3'd0,
        REG_THR  = 3'd2,
        REG_CTRL = 3'd4,
        REG_STAT = 3'd6
    } regOffset_e;

    // Control register bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_INV     = 1;
    localparam int CTRL_ONESHOT = 2;
    localparam int CTRL_IE      = 3;
    localparam int CTRL_BITS    = 4;

    // Status register bit positions
    localparam int STAT_DONE = 0;
    localparam int STAT_RUN  = 1;
    localparam int STAT_BITS = 2;

    // Threshold value after reset, before truncation to the channel width
    localparam logic [15:0] THR_RESET = 16'h7FFF;

    // Each channel owns 8 bytes, so the window needs 3 offset bits plus
    // enough bits to name every channel (a single channel still needs 3).
    function automatic int chanAddrWidth(input int numCh);
        return 3 + $clog2(numCh);
    endfunction

endpackage

// File: rtl/pwm_multi_if.sv
// -----------------------------------------------------------------------------
// pwm_multi_if
// Minisys-1A style memory-mapped bus as seen by the PWM peripheral.
//   write_enable   : one-cycle write strobe
//   read_enable    : read strobe, data returned one cycle later
//   address        : byte offset inside the peripheral window
//   write_data_in  : write data
//   read_data_out  : registered read data from the peripheral
// The master modport is the CPU side, the slave modport the peripheral side.
// -----------------------------------------------------------------------------
interface pwm_multi_if #(
    parameter int ADDR_W = 5
) ();

    logic              write_enable;
    logic              read_enable;
    logic [ADDR_W-1:0] address;
    logic [15:0]       write_data_in;
    logic [15:0]       read_data_out;

    modport master (
        output write_enable,
        output read_enable,
        output address,
        output write_data_in,
        input  read_data_out
    );

    modport slave (
        input  write_enable,
        input  read_enable,
        input  address,
        input  write_data_in,
        output read_data_out
    );

endinterface

// File: rtl/pwm_channel.sv
// -----------------------------------------------------------------------------
// pwm_channel
// One PWM channel: staging and active period/threshold registers, the period
// counter, control/status registers and the registered waveform output.
//   clock, reset_n : system clock, asynchronous active-low reset
//   i_wrMax        : write strobe for the staging maximum register
//   i_wrThr        : write strobe for the staging threshold register
//   i_wrCtrl       : write strobe for the control register
//   i_wrStat       : write strobe for the status register (write-1-to-clear)
//   i_wdata        : bus write data
//   o_maxStg       : staging maximum, for readback
//   o_thrStg       : staging threshold, for readback
//   o_ctrl         : control register, for readback
//   o_stat         : status register {running, done}, for readback
//   o_pwm          : registered PWM waveform
//   o_irq          : done & ie
// -----------------------------------------------------------------------------
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 i_wrMax,
    input  logic                 i_wrThr,
    input  logic                 i_wrCtrl,
    input  logic                 i_wrStat,
    input  logic [15:0]          i_wdata,
    output logic [WIDTH-1:0]     o_maxStg,
    output logic [WIDTH-1:0]     o_thrStg,
    output logic [CTRL_BITS-1:0] o_ctrl,
    output logic [STAT_BITS-1:0] o_stat,
    output logic                 o_pwm,
    output logic                 o_irq
);

    localparam logic [WIDTH-1:0] THR_INIT = THR_RESET[WIDTH-1:0];

    logic [WIDTH-1:0]     r_maxStg;
    logic [WIDTH-1:0]     r_thrStg;
    logic [WIDTH-1:0]     r_maxAct;
    logic [WIDTH-1:0]     r_thrAct;
    logic [WIDTH-1:0]     r_count;
    logic [CTRL_BITS-1:0] r_ctrl;
    logic                 r_done;
    logic                 r_pwm;

    logic                 w_en;
    logic                 w_boundary;
    logic                 w_raw;
    logic [WIDTH-1:0]     w_maxStgNext;
    logic [WIDTH-1:0]     w_thrStgNext;

    assign w_en       = r_ctrl[CTRL_EN];
    assign w_boundary = w_en && (r_count == r_maxAct);
    assign w_raw      = (r_count < r_thrAct);

    // The staging value as it will be after this edge. The active registers
    // load from this, so a staging write landing on a period boundary is
    // picked up by the new period straight away.
    assign w_maxStgNext = i_wrMax ? i_wdata[WIDTH-1:0] : r_maxStg;
    assign w_thrStgNext = i_wrThr ? i_wdata[WIDTH-1:0] : r_thrStg;

    // Staging registers are plain bus-written registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_maxStg <= '1;
            r_thrStg <= THR_INIT;
        end else begin
            r_maxStg <= w_maxStgNext;
            r_thrStg <= w_thrStgNext;
        end
    end

    // Active registers only change at a period boundary so a running waveform
    // never glitches. While disabled they track staging every cycle, which is
    // also what makes an enable write start from the freshest staging values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_maxAct <= '1;
            r_thrAct <= THR_INIT;
        end else if (!w_en || w_boundary) begin
            r_maxAct <= w_maxStgNext;
            r_thrAct <= w_thrStgNext;
        end
    end

    // The counter is parked at 0 while disabled, so the first enabled cycle
    // always starts a fresh period; otherwise it wraps after max_act.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (!w_en || w_boundary) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    // Control register. A bus write takes priority over the one-shot
    // hardware clear of the enable bit when both happen on the same edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl <= '0;
        end else if (i_wrCtrl) begin
            r_ctrl <= i_wdata[CTRL_BITS-1:0];
        end else if (w_boundary && r_ctrl[CTRL_ONESHOT]) begin
            r_ctrl[CTRL_EN] <= 1'b0;
        end
    end

    // Sticky done flag. Setting at a boundary wins over a simultaneous
    // write-1-to-clear so no period completion is ever lost.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_done <= 1'b0;
        end else if (w_boundary) begin
            r_done <= 1'b1;
        end else if (i_wrStat && i_wdata[STAT_DONE]) begin
            r_done <= 1'b0;
        end
    end

    // Output flop. When disabled the line rests at the inverted-idle level,
    // so an inverted channel idles high.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= w_en ? (w_raw ^ r_ctrl[CTRL_INV]) : r_ctrl[CTRL_INV];
        end
    end

    // Readback status word: running simply mirrors the enable bit.
    always_comb begin
        o_stat            = '0;
        o_stat[STAT_DONE] = r_done;
        o_stat[STAT_RUN]  = w_en;
    end

    assign o_maxStg = r_maxStg;
    assign o_thrStg = r_thrStg;
    assign o_ctrl   = r_ctrl;
    assign o_pwm    = r_pwm;
    assign o_irq    = r_done & r_ctrl[CTRL_IE];

endmodule

// File: rtl/pwm_multi.sv
// -----------------------------------------------------------------------------
// pwm_multi
// Multi-channel PWM peripheral on the memory-mapped bus. Decodes the bus
// address into a channel and register, instantiates NUM_CH channels, muxes
// the registered read data and ORs the channel interrupts.
//   clock, reset_n : system clock, asynchronous active-low reset
//   bus            : slave side of the peripheral bus (see pwm_multi_if)
//   pwm_out        : registered per-channel PWM waveforms
//   irq            : OR over channels of (done & ie)
// -----------------------------------------------------------------------------
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = chanAddrWidth(NUM_CH)
) (
    input  logic              clock,
    input  logic              reset_n,
    pwm_multi_if.slave        bus,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              irq
);

    logic [ADDR_W-1:0]    w_chField;
    logic [2:0]           w_regOff;
    logic                 w_offOk;
    logic [15:0]          w_rdData;
    logic [15:0]          r_rdData;

    logic [WIDTH-1:0]     w_maxStg [NUM_CH];
    logic [WIDTH-1:0]     w_thrStg [NUM_CH];
    logic [CTRL_BITS-1:0] w_ctrl   [NUM_CH];
    logic [STAT_BITS-1:0] w_stat   [NUM_CH];
    logic [NUM_CH-1:0]    w_pwmVec;
    logic [NUM_CH-1:0]    w_irqVec;

    // Upper address bits pick the channel; a shift rather than a slice keeps
    // the single-channel build (no channel bits at all) legal.
    assign w_chField = bus.address >> 3;
    assign w_regOff  = bus.address[2:0];
    assign w_offOk   = ~bus.address[0];

    // One channel per slot. A channel index beyond NUM_CH never matches any
    // slot, which is what makes those writes vanish.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic w_wrHit;

        assign w_wrHit = bus.write_enable && w_offOk && (w_chField == ADDR_W'(c));

        pwm_channel #(
            .WIDTH (WIDTH)
        ) u_channel (
            .clock    (clock),
            .reset_n  (reset_n),
            .i_wrMax  (w_wrHit && (w_regOff == REG_MAX)),
            .i_wrThr  (w_wrHit && (w_regOff == REG_THR)),
            .i_wrCtrl (w_wrHit && (w_regOff == REG_CTRL)),
            .i_wrStat (w_wrHit && (w_regOff == REG_STAT)),
            .i_wdata  (bus.write_data_in),
            .o_maxStg (w_maxStg[c]),
            .o_thrStg (w_thrStg[c]),
            .o_ctrl   (w_ctrl[c]),
            .o_stat   (w_stat[c]),
            .o_pwm    (w_pwmVec[c]),
            .o_irq    (w_irqVec[c])
        );
    end

    // Read mux. Period and threshold read back their staging copies, and
    // everything narrower than the bus is zero-extended. Odd offsets and
    // unpopulated channels read as zero.
    always_comb begin
        w_rdData = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_offOk && (w_chField == ADDR_W'(c))) begin
                case (w_regOff)
                    REG_MAX:  w_rdData = 16'(w_maxStg[c]);
                    REG_THR:  w_rdData = 16'(w_thrStg[c]);
                    REG_CTRL: w_rdData = 16'(w_ctrl[c]);
                    REG_STAT: w_rdData = 16'(w_stat[c]);
                    default:  w_rdData = '0;
                endcase
            end
        end
    end

    // Read data is captured on the strobe edge and held until the next read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rdData <= '0;
        end else if (bus.read_enable) begin
            r_rdData <= w_rdData;
        end
    end

    assign bus.read_data_out = r_rdData;
    assign pwm_out           = w_pwmVec;
    assign irq               = |w_irqVec;

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Parametrised multi-channel PWM peripheral on the Minisys-1A memory-mapped I/O bus; successor to the single-channel PWM.
- Provides NUM_CH independent channels, each with its own period, threshold and control registers.
- Shadowed period/threshold registers take effect only at the period boundary (glitch-free updates).
- Adds defined idle levels, polarity invert, one-shot mode, readback, and a sticky period-done status with interrupt.

Parameters:
- NUM_CH, 4, number of PWM channels (1..8).
- WIDTH, 16, counter/period/threshold width (8..16; bus data is 16 bits, upper bits zero-extended on read, ignored on write).
- ADDR_W, 3+$clog2(NUM_CH) (minimum 3), byte-address width within the peripheral window.

Ports:
- clock  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- write_enable  input  1  bus write strobe, one cycle per write
- read_enable  input  1  bus read strobe
- address  input  ADDR_W  byte offset: channel = address[ADDR_W-1:3], register = address[2:0]
- write_data_in  input  16  write data
- read_data_out  output  16  registered read data
- pwm_out  output  NUM_CH  per-channel PWM waveform, registered
- irq  output  1  OR over channels of (status.done & control.ie)

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - staging and active maximum = all ones; staging and active threshold = 0x7FFF truncated to WIDTH; control = 0; counter = 0; status = 0.
  - pwm_out = 0, read_data_out = 0, irq = 0.
  - No output is ever X.
- Register map per channel (offsets 0/2/4/6; odd offsets ignored):
  - 0 maximum (staging)
  - 2 threshold (staging)
  - 4 control: [0] en, [1] inv, [2] oneshot, [3] ie
  - 6 status: [0] done (sticky, write-1-to-clear), [1] running (read-only = en)
  - Addresses selecting a channel >= NUM_CH: writes ignored, reads return 0.
- Reads: read_data_out is loaded on the clock edge where read_enable=1, i.e. 1-cycle latency. Reading 0/2 returns the staging value, not the active value. When read_enable=0, read_data_out holds its value.
- Counter (per channel, WIDTH bits):
  - When en=1: counter increments each clock.
  - When counter == max_act: counter wraps to 0 and this is the period boundary. At the boundary, max_act/thr_act load from staging, and done is set.
  - Period = max_act+1 cycles.
- Waveform:
  - raw = (counter < thr_act).
  - pwm_out[c] <= en ? (raw ^ inv) : inv, so the idle level equals inv.
  - Output lags the counter by 1 cycle.
  - thr_act = 0: constant inactive level.
  - thr_act > max_act: constant active level.
  - max_act = 0: period of 1 cycle.
- Enable edge: a write setting en 0->1 forces counter = 0 and loads max_act/thr_act from staging (using the value being written that cycle if the same write targets them — not possible, since a write addresses one register). The first active output appears on the next edge.
- Disable: en=0 holds counter at 0. Active registers follow staging each cycle while disabled.
- One-shot: if oneshot=1 at a period boundary, hardware clears en and pwm_out returns to idle on the following edge.
- Simultaneous events:
  - A bus write to control in the same cycle as a one-shot clear: the bus write wins.
  - A bus write-1-clear of done in the same cycle as a boundary: done stays set (set wins).
  - A staging write in the same cycle as a boundary: the active register takes the newly written value.
- Reset mid-period: all channels asynchronously return to reset values; pwm_out drops to 0 immediately.

Decomposition:
- Shared package pwm_pkg holds:
  - Register offset constants (REG_MAX=0, REG_THR=2, REG_CTRL=4, REG_STAT=6).
  - Control bit indices (CTRL_EN, CTRL_INV, CTRL_ONESHOT, CTRL_IE) and status bit indices (STAT_DONE, STAT_RUN).
- One sub-module, pwm_channel (parameter WIDTH), covers one channel's staging/active registers, counter, control/status and output flop.
- The top level does address decode, a generate loop over NUM_CH, the read mux and the irq OR.

Test Plan:
- Reset, then NUM_CH=4, WIDTH=16: read offsets 0/2/4/6 of channel 0 -> 0xFFFF, 0x7FFF, 0x0000, 0x0000; pwm_out = 4'b0000 before and after reset release.
- Ch1: max=9, thr=3, ctrl=0x1 -> pwm_out[1] high 3 cycles, low 7, repeating with period 10; first high on the edge after the enable write.
- Ch1 running (max=9, thr=3): write thr=7 mid-period -> current period keeps 3 high cycles; the next period has 7.
- Ch2: max=4, thr=2, ctrl=0x5 (one-shot) -> exactly one 2-high/3-low period, then en reads 0, status reads 0x1. Write status 0x1 -> status reads 0x0.
- Ch3: ctrl=0x3 (en+inv) with thr=0 -> pwm_out[3] constant 1. Then thr=10 with max=5 -> constant 0 after the next boundary. Then ctrl=0x2 -> idle 1.
- Ch0: ie=1, one-shot, max=2 -> irq rises 3 cycles after enable; assert reset_n=0 mid-period -> irq, pwm_out and all registers return to reset values asynchronously.
